// File: rtl/wb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// wb_regfile_pkg
//
// Purpose:
//   Shared definitions for the write-back register file slice. Holds the
//   default datapath and index widths, the bit positions inside the
//   two-bit write_back_signal control field, the hard-wired zero register
//   index, and the width of the committed-write counter.
//
// Contents:
//   DATA_W_DEF      default register/datapath width
//   ADDR_W_DEF      default register index width (2**ADDR_W registers)
//   COUNT_W         width of the committed-write counter
//   WB_REG_WRITE    write_back_signal bit that requests a register write
//   WB_MEM_TO_REG   write_back_signal bit that selects load data
//   ZERO_REG        index of the register that always reads zero
//   wb_is_write()   decodes the reg_write request from write_back_signal
// ---------------------------------------------------------------------------
package wb_regfile_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 5;
  localparam int COUNT_W       = 32;

  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  localparam int ZERO_REG      = 0;

  // Extracts the reg_write request; the zero-register filter is applied
  // separately because it depends on the destination index.
  function automatic logic wb_is_write(input logic [1:0] wbs);
    return wbs[WB_REG_WRITE];
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// ---------------------------------------------------------------------------
// wb_regfile_if
//
// Purpose:
//   Bundles the MEM/WB write-back bus, the decode-stage read ports and the
//   forwarding/status outputs of the register file into one interface.
//
// Parameters:
//   DATA_W  register and datapath width
//   ADDR_W  register index width
//
// Signals:
//   result             ALU result from the MEM/WB register
//   read_data          memory load data from the MEM/WB register
//   reg_dst            destination register index
//   write_back_signal  [1] reg_write, [0] mem_to_reg
//   rs_addr, rt_addr   decode-stage read indices
//   rs_data, rt_data   read-port data
//   wb_data            selected write-back value (for EX forwarding)
//   wb_we              effective write enable
//   wb_count           number of committed register writes
//
// Modports:
//   slave   register file side (consumes the bus, drives read data/status)
//   master  pipeline side (drives the bus, consumes read data/status)
// ---------------------------------------------------------------------------
interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [DATA_W-1:0]  result;
  logic [DATA_W-1:0]  read_data;
  logic [ADDR_W-1:0]  reg_dst;
  logic [1:0]         write_back_signal;
  logic [ADDR_W-1:0]  rs_addr;
  logic [ADDR_W-1:0]  rt_addr;

  logic [DATA_W-1:0]  rs_data;
  logic [DATA_W-1:0]  rt_data;
  logic [DATA_W-1:0]  wb_data;
  logic               wb_we;
  logic [COUNT_W-1:0] wb_count;

  modport slave (
    input  result,
    input  read_data,
    input  reg_dst,
    input  write_back_signal,
    input  rs_addr,
    input  rt_addr,
    output rs_data,
    output rt_data,
    output wb_data,
    output wb_we,
    output wb_count
  );

  modport master (
    output result,
    output read_data,
    output reg_dst,
    output write_back_signal,
    output rs_addr,
    output rt_addr,
    input  rs_data,
    input  rt_data,
    input  wb_data,
    input  wb_we,
    input  wb_count
  );

endinterface

// File: rtl/wb_regfile_wb_mux.sv
// ---------------------------------------------------------------------------
// wb_mux
//
// Purpose:
//   Write-back source selection. Chooses between the ALU result and the
//   memory load data. The selection is independent of reg_write so that
//   the EX stage can always forward the value the WB stage is carrying.
//
// Ports:
//   result      in   DATA_W  ALU result
//   read_data   in   DATA_W  memory load data
//   mem_to_reg  in   1       1 selects read_data, 0 selects result
//   wb_data     out  DATA_W  selected write-back value
// ---------------------------------------------------------------------------
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] read_data,
  input  logic              mem_to_reg,
  output logic [DATA_W-1:0] wb_data
);

  always_comb begin
    wb_data = result;
    if (mem_to_reg) begin
      wb_data = read_data;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//
// Purpose:
//   Pipeline register file with the write-back stage folded in. The WB
//   stage value is selected from the ALU result or load data, written into
//   the addressed register on the next rising edge, and counted. Register 0
//   is hard-wired to zero and writes to it are dropped without being
//   counted. Two independent combinational read ports serve decode.
//
// Parameters:
//   DATA_W  register and datapath width (default 32)
//   ADDR_W  register index width (default 5, giving 32 registers)
//
// Ports:
//   clk   in  1                 sole clock, rising edge
//   rst   in  1                 synchronous active-high reset
//   bus   wb_regfile_if.slave   write-back bus, read ports, status
//
// Configuration:
//   WB_REGFILE_BYPASS_EN  when defined, a read port addressing the register
//                         being written this cycle returns the write-back
//                         value immediately. When undefined, read ports
//                         return array contents only, so the new value is
//                         visible one cycle after the write.
// ---------------------------------------------------------------------------
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [DATA_W-1:0]  regs_d [NUM_REGS];
  logic [COUNT_W-1:0] wb_count_q;
  logic [COUNT_W-1:0] wb_count_d;

  logic [DATA_W-1:0]  wb_data;
  logic               wb_we;
  logic [DATA_W-1:0]  rs_rd_data;
  logic [DATA_W-1:0]  rt_rd_data;

  wb_mux #(
    .DATA_W (DATA_W)
  ) u_wb_mux (
    .result     (bus.result),
    .read_data  (bus.read_data),
    .mem_to_reg (bus.write_back_signal[WB_MEM_TO_REG]),
    .wb_data    (wb_data)
  );

  // A write to the zero register is not a write at all: it neither lands
  // in the array nor bumps the counter, so it is filtered out here once.
  always_comb begin
    wb_we = wb_is_write(bus.write_back_signal) &&
            (bus.reg_dst != ADDR_W'(ZERO_REG));
  end

  // Next-state for the array and the counter. The counter wraps naturally
  // at its full width.
  always_comb begin
    regs_d     = regs_q;
    wb_count_d = wb_count_q;
    if (wb_we) begin
      regs_d[bus.reg_dst] = wb_data;
      wb_count_d          = wb_count_q + COUNT_W'(1);
    end
  end

  // Reset takes priority over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wb_count_q <= wb_count_d;
    end
  end

  // rs read port. The zero-register override comes last so it also wins
  // over the bypass path.
  always_comb begin
    rs_rd_data = regs_q[bus.rs_addr];
`ifdef WB_REGFILE_BYPASS_EN
    if (wb_we && (bus.rs_addr == bus.reg_dst)) begin
      rs_rd_data = wb_data;
    end
`endif
    if (bus.rs_addr == ADDR_W'(ZERO_REG)) begin
      rs_rd_data = '0;
    end
  end

  // rt read port, identical to rs so equal addresses give equal data.
  always_comb begin
    rt_rd_data = regs_q[bus.rt_addr];
`ifdef WB_REGFILE_BYPASS_EN
    if (wb_we && (bus.rt_addr == bus.reg_dst)) begin
      rt_rd_data = wb_data;
    end
`endif
    if (bus.rt_addr == ADDR_W'(ZERO_REG)) begin
      rt_rd_data = '0;
    end
  end

  assign bus.rs_data  = rs_rd_data;
  assign bus.rt_data  = rt_rd_data;
  assign bus.wb_data  = wb_data;
  assign bus.wb_we    = wb_we;
  assign bus.wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//
// Purpose:
//   Self-checking bench for wb_regfile. Inputs change on the falling edge,
//   outputs are sampled shortly after, and the reference model (a plain
//   array of register values plus a write counter) is advanced on the
//   rising edge. Directed scenarios cover the named behaviours; a random
//   phase follows.
// ---------------------------------------------------------------------------
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] model_regs [32];
  logic [31:0] model_count;

  logic [31:0] last_rs;
  logic [31:0] last_rt;
  logic [31:0] last_wb_data;
  logic [31:0] last_count;
  logic        last_we;

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Architectural read as seen by decode in the current cycle.
  function automatic logic [31:0] expRead(input logic [4:0] addr,
                                          input logic we,
                                          input logic [4:0] dst,
                                          input logic [31:0] wbd);
    if (addr == 5'd0) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
    if (we && addr == dst) return wbd;
`endif
    return model_regs[addr];
  endfunction

  // One cycle: drive, check combinational view, then commit in the model.
  task automatic applyStimulus(input logic rst_in, input logic [1:0] wbs,
                               input logic [31:0] res, input logic [31:0] rdata,
                               input logic [4:0] dst, input logic [4:0] rs_a,
                               input logic [4:0] rt_a);
    logic [31:0] exp_wbd;
    logic        exp_we;
    @(negedge clk);
    rst                   = rst_in;
    bus.write_back_signal = wbs;
    bus.result            = res;
    bus.read_data         = rdata;
    bus.reg_dst           = dst;
    bus.rs_addr           = rs_a;
    bus.rt_addr           = rt_a;
    exp_wbd = wbs[0] ? rdata : res;
    exp_we  = wbs[1] && (dst != 5'd0);
    #1;
    last_rs      = bus.rs_data;
    last_rt      = bus.rt_data;
    last_wb_data = bus.wb_data;
    last_count   = bus.wb_count;
    last_we      = bus.wb_we;
    checkOutput("wb_data", bus.wb_data, exp_wbd);
    checkOutput("wb_we", {31'd0, bus.wb_we}, {31'd0, exp_we});
    checkOutput("rs_data", bus.rs_data, expRead(rs_a, exp_we, dst, exp_wbd));
    checkOutput("rt_data", bus.rt_data, expRead(rt_a, exp_we, dst, exp_wbd));
    checkOutput("wb_count", bus.wb_count, model_count);
    @(posedge clk);
    if (rst_in) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_count = 32'd0;
    end else if (exp_we) begin
      model_regs[dst] = exp_wbd;
      model_count     = model_count + 32'd1;
    end
  endtask

  initial begin
    logic [1:0]  r_wbs;
    logic [4:0]  r_dst;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic        r_rst;

    rst                   = 1'b1;
    bus.write_back_signal = 2'b00;
    bus.result            = 32'd0;
    bus.read_data         = 32'd0;
    bus.reg_dst           = 5'd0;
    bus.rs_addr           = 5'd0;
    bus.rt_addr           = 5'd0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    model_count = 32'd0;

    // Cleared array readable on every index from both ports.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'(i), 5'(31 - i));
      checkOutput("reset_rs", last_rs, 32'd0);
      checkOutput("reset_rt", last_rt, 32'd0);
    end
    checkOutput("reset_count", last_count, 32'd0);

    // ALU write then load write to register 5.
    applyStimulus(1'b0, 2'b10, 32'h1234_5678, 32'h0BAD_0BAD, 5'd5, 5'd0, 5'd0);
    applyStimulus(1'b0, 2'b11, 32'h0000_1111, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5);
`ifndef WB_REGFILE_BYPASS_EN
    checkOutput("alu_write_rs", last_rs, 32'h1234_5678);
`endif
    checkOutput("alu_write_count", last_count, 32'd1);
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd5, 5'd5);
    checkOutput("load_write_rs", last_rs, 32'hDEAD_BEEF);
    checkOutput("load_write_count", last_count, 32'd2);

    // Write to register 0 is dropped and not counted.
    applyStimulus(1'b0, 2'b10, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd0, 5'd0);
    checkOutput("zero_we", {31'd0, last_we}, 32'd0);
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    checkOutput("zero_rs", last_rs, 32'd0);
    checkOutput("zero_count", last_count, 32'd2);

    // mem_to_reg without reg_write: forwarded value only.
    applyStimulus(1'b0, 2'b01, 32'd0, 32'hAAAA_AAAA, 5'd7, 5'd7, 5'd7);
    checkOutput("nowrite_wbdata", last_wb_data, 32'hAAAA_AAAA);
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd7, 5'd7);
    checkOutput("nowrite_r7", last_rs, 32'd0);

    // Same-cycle read of the register being written.
    applyStimulus(1'b0, 2'b10, 32'h0000_0011, 32'd0, 5'd9, 5'd0, 5'd0);
    applyStimulus(1'b0, 2'b10, 32'h0000_0055, 32'd0, 5'd9, 5'd9, 5'd9);
`ifdef WB_REGFILE_BYPASS_EN
    checkOutput("rw_same_rs", last_rs, 32'h0000_0055);
    checkOutput("rw_same_rt", last_rt, 32'h0000_0055);
`else
    checkOutput("rw_same_rs", last_rs, 32'h0000_0011);
    checkOutput("rw_same_rt", last_rt, 32'h0000_0011);
`endif
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd9, 5'd9);
    checkOutput("rw_next_rs", last_rs, 32'h0000_0055);
    checkOutput("rw_next_rt", last_rt, 32'h0000_0055);

    // Counter wrap from all-ones.
    @(negedge clk);
    rst                   = 1'b0;
    bus.write_back_signal = 2'b00;
    force dut.wb_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count_q;
    model_count = 32'hFFFF_FFFF;
    applyStimulus(1'b0, 2'b10, 32'h0000_0444, 32'd0, 5'd4, 5'd0, 5'd0);
    checkOutput("wrap_before", last_count, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd4, 5'd4);
    checkOutput("wrap_after", last_count, 32'd0);

    // Reset coincident with a write to register 3.
    applyStimulus(1'b0, 2'b10, 32'h0000_0033, 32'd0, 5'd3, 5'd0, 5'd0);
    applyStimulus(1'b1, 2'b10, 32'h0000_0099, 32'd0, 5'd3, 5'd3, 5'd4);
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd3, 5'd4);
    checkOutput("rst_write_r3", last_rs, 32'd0);
    checkOutput("rst_clear_r4", last_rt, 32'd0);
    checkOutput("rst_count", last_count, 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      r_rst = ($urandom_range(0, 59) == 0);
      r_wbs = 2'($urandom_range(0, 3));
      r_dst = 5'($urandom_range(0, 31));
      r_rs  = ($urandom_range(0, 3) == 0) ? r_dst : 5'($urandom_range(0, 31));
      r_rt  = ($urandom_range(0, 3) == 0) ? r_rs  : 5'($urandom_range(0, 31));
      applyStimulus(r_rst, r_wbs, $urandom, $urandom, r_dst, r_rs, r_rt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
